apu_pulse_multi: RTL and testbench

- Parametrised successor to the single pulse channel: NUM_CH independent NES-style pulse generators with a shared valid/ready config port and a summed (mixed) output sample stream.
- Sits between the pad-level tile wrapper and the audio DAC/PWM stage. Config comes from host pins; mixed samples are pulled by the downstream consumer.
- Per-channel mute below a minimum period; channel-enable mask; sample-driven timebase, so the block stalls when the consumer stalls.

---
 rtl/apu_pulse_multi.sv | 172 +++++++++++++++++
 tb/tb_apu_pulse_multi.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_pulse_multi.sv
// apu_pulse_multi
//   NUM_CH independent NES-style pulse generators sharing one valid/ready
//   config port. Their enabled output bits are summed into a single sample
//   stream that the downstream consumer pulls.
//
//   The timebase is driven by the samples themselves. Every time a sample is
//   loaded, each channel advances by one tick. This means the whole block
//   freezes while the consumer holds off mix_rdy.
//
//   Optional feature: define APU_PULSE_MULTI_VOLUME_EN to add 4-bit
//   per-channel volume (ports cfg_vol/cfg_vol_vld/cfg_vol_rdy). With it
//   defined, each enabled channel adds its volume to the mix instead of 1.
module apu_pulse_multi #(
    parameter int NUM_CH     = 2,
    parameter int PERIOD_W   = 11,
    parameter int MIN_PERIOD = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef APU_PULSE_MULTI_VOLUME_EN
    parameter int MIX_W      = $clog2(NUM_CH * 15 + 1)
`else
    parameter int MIX_W      = $clog2(NUM_CH + 1)
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_period_vld,
    output logic                cfg_period_rdy,
    input  logic [1:0]          cfg_duty,
    input  logic                cfg_duty_vld,
    output logic                cfg_duty_rdy,
`ifdef APU_PULSE_MULTI_VOLUME_EN
    input  logic [3:0]          cfg_vol,
    input  logic                cfg_vol_vld,
    output logic                cfg_vol_rdy,
`endif
    input  logic [NUM_CH-1:0]   ch_en,
    output logic [MIX_W-1:0]    mix_data,
    output logic                mix_vld,
    input  logic                mix_rdy,
    output logic [NUM_CH-1:0]   ch_out
);

    // Per-channel state.
    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] timer_q  [NUM_CH];
    logic [1:0]          duty_q   [NUM_CH];
    logic [2:0]          step_q   [NUM_CH];
`ifdef APU_PULSE_MULTI_VOLUME_EN
    logic [3:0]          vol_q    [NUM_CH];
`endif

    // Output sample register and handshake state.
    logic [MIX_W-1:0]  mixData_q;
    logic [MIX_W-1:0]  mixData_d;
    logic [NUM_CH-1:0] chOut_q;
    logic [NUM_CH-1:0] chOut_d;
    logic              mixVld_q;
    logic              cfgRdy_q;

    logic loadEn;
    logic periodWr;
    logic dutyWr;
`ifdef APU_PULSE_MULTI_VOLUME_EN
    logic volWr;
`endif

    // High portion of the 8-step sequence for each duty code:
    // duty 0..3 gives 1, 2, 4 and 6 high steps.
    function automatic logic dutyHigh(input logic [1:0] duty, input logic [2:0] step);
        logic hi;
        case (duty)
            2'd0:    hi = (step < 3'd1);
            2'd1:    hi = (step < 3'd2);
            2'd2:    hi = (step < 3'd4);
            default: hi = (step < 3'd6);
        endcase
        return hi;
    endfunction

    // A new sample is taken whenever the output slot is empty or is being consumed.
    assign loadEn   = !mixVld_q || mix_rdy;
    assign periodWr = cfg_period_vld && cfgRdy_q;
    assign dutyWr   = cfg_duty_vld && cfgRdy_q;
`ifdef APU_PULSE_MULTI_VOLUME_EN
    assign volWr    = cfg_vol_vld && cfgRdy_q;
`endif

    // Build the next sample from the current channel state: raw bits plus the enabled sum.
    always_comb begin
        chOut_d   = '0;
        mixData_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chOut_d[i] = (period_q[i] >= PERIOD_W'(MIN_PERIOD)) && dutyHigh(duty_q[i], step_q[i]);
            if (chOut_d[i] && ch_en[i]) begin
`ifdef APU_PULSE_MULTI_VOLUME_EN
                mixData_d = mixData_d + MIX_W'(vol_q[i]);
`else
                mixData_d = mixData_d + MIX_W'(1);
`endif
            end
        end
    end

    // Output register: capture a sample on each load; config becomes ready one cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mixData_q <= '0;
            chOut_q   <= '0;
            mixVld_q  <= 1'b0;
            cfgRdy_q  <= 1'b0;
        end else begin
            cfgRdy_q <= 1'b1;
            if (loadEn) begin
                mixData_q <= mixData_d;
                chOut_q   <= chOut_d;
                mixVld_q  <= 1'b1;
            end
        end
    end

    // Channel timers tick once per load. A config write to a channel overrides
    // that channel's tick, and an out-of-range cfg_ch matches no channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                timer_q[i]  <= '0;
                duty_q[i]   <= '0;
                step_q[i]   <= '0;
`ifdef APU_PULSE_MULTI_VOLUME_EN
                vol_q[i]    <= 4'd15;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (loadEn) begin
                    if (timer_q[i] == '0) begin
                        timer_q[i] <= period_q[i];
                        step_q[i]  <= step_q[i] + 3'd1;
                    end else begin
                        timer_q[i] <= timer_q[i] - PERIOD_W'(1);
                    end
                end
                if (periodWr && (cfg_ch == CH_W'(i))) begin
                    period_q[i] <= cfg_period;
                    timer_q[i]  <= cfg_period;
                    step_q[i]   <= 3'd0;
                end
                if (dutyWr && (cfg_ch == CH_W'(i))) begin
                    duty_q[i] <= cfg_duty;
                end
`ifdef APU_PULSE_MULTI_VOLUME_EN
                if (volWr && (cfg_ch == CH_W'(i))) begin
                    vol_q[i] <= cfg_vol;
                end
`endif
            end
        end
    end

    assign mix_data       = mixData_q;
    assign ch_out         = chOut_q;
    assign mix_vld        = mixVld_q;
    assign cfg_period_rdy = cfgRdy_q;
    assign cfg_duty_rdy   = cfgRdy_q;
`ifdef APU_PULSE_MULTI_VOLUME_EN
    assign cfg_vol_rdy    = cfgRdy_q;
`endif

endmodule

// File: tb/tb_apu_pulse_multi.sv
// tb_apu_pulse_multi
//   Directed bench for apu_pulse_multi.
//
//   Expected samples come from a closed-form waveform model. Each channel
//   tracks a phase counter of ticks since its last period write; its bit is
//   high when (phase / (period+1)) mod 8 is below the duty's high-step count.
//
//   A second instance with NUM_CH=3 checks that a write to a channel index
//   that does not exist is accepted and then dropped.
module tb_apu_pulse_multi;

    localparam int NUM_CH   = 2;
    localparam int PERIOD_W = 11;
    localparam int CH_W     = 1;
`ifdef APU_PULSE_MULTI_VOLUME_EN
    localparam int MIX_W    = $clog2(NUM_CH * 15 + 1);
    localparam int MIX3_W   = $clog2(3 * 15 + 1);
    localparam int UNIT     = 15;
`else
    localparam int MIX_W    = $clog2(NUM_CH + 1);
    localparam int MIX3_W   = $clog2(3 + 1);
    localparam int UNIT     = 1;
`endif

    logic                clk;
    logic                rst_n;
    logic [CH_W-1:0]     cfgCh;
    logic [PERIOD_W-1:0] cfgPeriod;
    logic                cfgPeriodVld;
    logic                cfgPeriodRdy;
    logic [1:0]          cfgDuty;
    logic                cfgDutyVld;
    logic                cfgDutyRdy;
    logic [NUM_CH-1:0]   chEn;
    logic [MIX_W-1:0]    mixData;
    logic                mixVld;
    logic                mixRdy;
    logic [NUM_CH-1:0]   chOut;

    logic [1:0]          cfgCh3;
    logic [PERIOD_W-1:0] cfgPeriod3;
    logic                cfgPeriodVld3;
    logic                cfgPeriodRdy3;
    logic [1:0]          cfgDuty3;
    logic                cfgDutyVld3;
    logic                cfgDutyRdy3;
    logic [2:0]          chEn3;
    logic [MIX3_W-1:0]   mixData3;
    logic                mixVld3;
    logic                mixRdy3;
    logic [2:0]          chOut3;

`ifdef APU_PULSE_MULTI_VOLUME_EN
    logic [3:0] cfgVol;
    logic       cfgVolVld;
    logic       cfgVolRdy;
    logic [3:0] cfgVol3;
    logic       cfgVolVld3;
    logic       cfgVolRdy3;
`endif

    apu_pulse_multi #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .MIN_PERIOD(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_ch         (cfgCh),
        .cfg_period     (cfgPeriod),
        .cfg_period_vld (cfgPeriodVld),
        .cfg_period_rdy (cfgPeriodRdy),
        .cfg_duty       (cfgDuty),
        .cfg_duty_vld   (cfgDutyVld),
        .cfg_duty_rdy   (cfgDutyRdy),
`ifdef APU_PULSE_MULTI_VOLUME_EN
        .cfg_vol        (cfgVol),
        .cfg_vol_vld    (cfgVolVld),
        .cfg_vol_rdy    (cfgVolRdy),
`endif
        .ch_en          (chEn),
        .mix_data       (mixData),
        .mix_vld        (mixVld),
        .mix_rdy        (mixRdy),
        .ch_out         (chOut)
    );

    apu_pulse_multi #(.NUM_CH(3), .PERIOD_W(PERIOD_W), .MIN_PERIOD(8)) dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_ch         (cfgCh3),
        .cfg_period     (cfgPeriod3),
        .cfg_period_vld (cfgPeriodVld3),
        .cfg_period_rdy (cfgPeriodRdy3),
        .cfg_duty       (cfgDuty3),
        .cfg_duty_vld   (cfgDutyVld3),
        .cfg_duty_rdy   (cfgDutyRdy3),
`ifdef APU_PULSE_MULTI_VOLUME_EN
        .cfg_vol        (cfgVol3),
        .cfg_vol_vld    (cfgVolVld3),
        .cfg_vol_rdy    (cfgVolRdy3),
`endif
        .ch_en          (chEn3),
        .mix_data       (mixData3),
        .mix_vld        (mixVld3),
        .mix_rdy        (mixRdy3),
        .ch_out         (chOut3)
    );

    typedef struct packed {
        logic [MIX_W-1:0]  mix;
        logic [NUM_CH-1:0] ch;
    } sample_t;

    int      checks;
    int      errors;
    int      modelPeriod [NUM_CH];
    int      modelDuty   [NUM_CH];
    int      modelPhase  [NUM_CH];
    bit      expVld;
    bit      expRdy;
    sample_t sbQ [$];
    sample_t lastExp;

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the directed sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    function automatic void resetModel();
        for (int c = 0; c < NUM_CH; c++) begin
            modelPeriod[c] = 0;
            modelDuty[c]   = 0;
            modelPhase[c]  = 0;
        end
        expVld  = 1'b0;
        expRdy  = 1'b0;
        sbQ.delete();
        lastExp = '0;
    endfunction

    function automatic logic modelBit(input int c);
        int n;
        case (modelDuty[c])
            0:       n = 1;
            1:       n = 2;
            2:       n = 4;
            default: n = 6;
        endcase
        return (modelPeriod[c] >= 8) && (((modelPhase[c] / (modelPeriod[c] + 1)) % 8) < n);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles with the current inputs. Each cycle predicts any load,
    // updates the model, waits for the edge, then checks the DUT.
    task automatic applyStimulus(input int n);
        bit      loadNow;
        sample_t s;
        for (int k = 0; k < n; k++) begin
            loadNow = !expVld || mixRdy;
            if (loadNow) begin
                s = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    s.ch[c] = modelBit(c);
                    if (s.ch[c] && chEn[c]) s.mix = s.mix + MIX_W'(UNIT);
                end
                sbQ.push_back(s);
                for (int c = 0; c < NUM_CH; c++) modelPhase[c]++;
            end
            if (expRdy && cfgPeriodVld) begin
                modelPeriod[cfgCh] = int'(cfgPeriod);
                modelPhase[cfgCh]  = 0;
            end
            if (expRdy && cfgDutyVld) modelDuty[cfgCh] = int'(cfgDuty);
            @(posedge clk);
            #1;
            cfgPeriodVld  = 1'b0;
            cfgDutyVld    = 1'b0;
            cfgPeriodVld3 = 1'b0;
            cfgDutyVld3   = 1'b0;
            if (loadNow) begin
                lastExp = sbQ.pop_front();
                expVld  = 1'b1;
            end
            expRdy = 1'b1;
            checkOutput("mix_vld",        32'(mixVld),       32'(expVld));
            checkOutput("mix_data",       32'(mixData),      32'(lastExp.mix));
            checkOutput("ch_out",         32'(chOut),        32'(lastExp.ch));
            checkOutput("cfg_period_rdy", 32'(cfgPeriodRdy), 32'(expRdy));
            checkOutput("cfg_duty_rdy",   32'(cfgDutyRdy),   32'(expRdy));
        end
    endtask

    task automatic writeCfg(input bit doPer, input bit doDuty, input logic [CH_W-1:0] ch,
                            input logic [PERIOD_W-1:0] per, input logic [1:0] duty);
        cfgCh        = ch;
        cfgPeriod    = per;
        cfgPeriodVld = doPer;
        cfgDuty      = duty;
        cfgDutyVld   = doDuty;
        applyStimulus(1);
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cfgCh = '0; cfgPeriod = '0; cfgPeriodVld = 1'b0; cfgDuty = '0; cfgDutyVld = 1'b0;
        chEn = '0; mixRdy = 1'b1;
        cfgCh3 = '0; cfgPeriod3 = '0; cfgPeriodVld3 = 1'b0; cfgDuty3 = '0; cfgDutyVld3 = 1'b0;
        chEn3 = 3'b111; mixRdy3 = 1'b1;
`ifdef APU_PULSE_MULTI_VOLUME_EN
        cfgVol = '0; cfgVolVld = 1'b0; cfgVol3 = '0; cfgVolVld3 = 1'b0;
`endif
        resetModel();

        #12;
        checkOutput("reset mix_vld",  32'(mixVld),       32'd0);
        checkOutput("reset mix_data", 32'(mixData),      32'd0);
        checkOutput("reset ch_out",   32'(chOut),        32'd0);
        checkOutput("reset per_rdy",  32'(cfgPeriodRdy), 32'd0);
        checkOutput("reset duty_rdy", 32'(cfgDutyRdy),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] idle after reset");
        chEn = 2'b11;
        applyStimulus(6);

        $display("[TB] ch0 period 8 duty 2, then duty 0");
        chEn = 2'b01;
        writeCfg(1'b1, 1'b1, 1'b0, 11'd8, 2'd2);
        applyStimulus(80);
        writeCfg(1'b0, 1'b1, 1'b0, 11'd0, 2'd0);
        applyStimulus(72);

        $display("[TB] two channels offset by one sample");
        chEn = 2'b11;
        writeCfg(1'b1, 1'b1, 1'b0, 11'd8, 2'd3);
        writeCfg(1'b1, 1'b1, 1'b1, 11'd8, 2'd3);
        applyStimulus(80);
        chEn = 2'b01;
        applyStimulus(40);

        $display("[TB] period below minimum mutes, rewrite resumes");
        writeCfg(1'b1, 1'b1, 1'b0, 11'd7, 2'd3);
        applyStimulus(20);
        writeCfg(1'b1, 1'b0, 1'b0, 11'd8, 2'd3);
        applyStimulus(20);

        $display("[TB] consumer stall");
        mixRdy = 1'b0;
        applyStimulus(20);
        mixRdy = 1'b1;
        applyStimulus(40);

        $display("[TB] asynchronous reset mid-stream");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async mix_vld",  32'(mixVld),       32'd0);
        checkOutput("async mix_data", 32'(mixData),      32'd0);
        checkOutput("async ch_out",   32'(chOut),        32'd0);
        checkOutput("async per_rdy",  32'(cfgPeriodRdy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held mix_vld",   32'(mixVld),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        chEn = 2'b11;
        applyStimulus(5);

        $display("[TB] out-of-range channel write on 3-channel instance");
        cfgCh3        = 2'd3;
        cfgPeriod3    = 11'd8;
        cfgPeriodVld3 = 1'b1;
        cfgDuty3      = 2'd3;
        cfgDutyVld3   = 1'b1;
        checkOutput("oor per_rdy",  32'(cfgPeriodRdy3), 32'd1);
        checkOutput("oor duty_rdy", 32'(cfgDutyRdy3),   32'd1);
        applyStimulus(1);
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1);
            checkOutput("oor mix_vld",  32'(mixVld3),  32'd1);
            checkOutput("oor mix_data", 32'(mixData3), 32'd0);
            checkOutput("oor ch_out",   32'(chOut3),   32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
